// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one request at a time and queues returned words.
// Optional same-cycle response bypass to the consumer when built with PFQ_BYPASS_EN.
module fetch_prefetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  RedirectPC,
    output logic               IMemReq,
    output logic [ADDR_W-1:0]  IMemAddr,
    input  logic               IMemValid,
    input  logic [INSTR_W-1:0] IMemData,
    output logic               InstrValid,
    input  logic               InstrReady,
    output logic [INSTR_W-1:0] Instruction,
    output logic [ADDR_W-1:0]  UpdatedPC
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [INSTR_W-1:0]  instr_mem_q [DEPTH];
    logic [ADDR_W-1:0]   pc_mem_q    [DEPTH];

    logic queue_valid;
    logic resp_live;
    logic bypass_valid;
    logic bypass_take;
    logic req_ok;
    logic push;
    logic pop;
    logic head_valid;

    assign queue_valid = (count_q != '0);
    assign resp_live   = (state_q == S_WAIT) && IMemValid;
    // Only IDLE can issue, so the single in-flight word always has a free slot reserved.
    assign req_ok      = (state_q == S_IDLE) && !Redirect && (count_q < DEPTH_C);

`ifdef PFQ_BYPASS_EN
    assign bypass_valid = resp_live && !queue_valid && !Redirect;
`else
    assign bypass_valid = 1'b0;
`endif

    assign bypass_take = bypass_valid && InstrReady;
    assign push        = resp_live && !Redirect && !bypass_take;
    assign pop         = queue_valid && InstrReady && !Redirect;
    assign head_valid  = Reset && !Redirect && (queue_valid || bypass_valid);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A redirect in DISCARD keeps waiting for the in-flight word; once it lands, fetch resumes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_ok) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (IMemValid)     state_d = S_IDLE;
                else if (Redirect) state_d = S_DISCARD;
            end
            S_DISCARD: begin
                if (IMemValid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        IMemReq     = Reset && req_ok;
        IMemAddr    = fetch_pc_q;
        InstrValid  = head_valid;
        Instruction = '0;
        UpdatedPC   = '0;
        if (head_valid) begin
            if (queue_valid) begin
                Instruction = instr_mem_q[rd_ptr_q];
                UpdatedPC   = pc_mem_q[rd_ptr_q];
            end else begin
                Instruction = IMemData;
                UpdatedPC   = fetch_pc_q + STEP_C;
            end
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (Redirect) begin
            fetch_pc_d = RedirectPC;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (resp_live) fetch_pc_d = fetch_pc_q + STEP_C;
            if (push)      wr_ptr_d   = wr_ptr_q + PW'(1);
            if (pop)       rd_ptr_d   = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= IMemData;
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q + STEP_C;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue; a second instance exercises PC wrap from RESET_PC=FFFF_FFF8.
// Expectations for the PFQ_BYPASS_EN build are selected with the same macro.
module tb_fetch_prefetch_queue;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemValid;
    logic [31:0] IMemData;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instruction;
    logic [31:0] UpdatedPC;

    logic        wRedirect;
    logic [31:0] wRedirectPC;
    logic        wReq;
    logic [31:0] wAddr;
    logic        wValid;
    logic [31:0] wData;
    logic        wInstrValid;
    logic        wReady;
    logic [31:0] wInstruction;
    logic [31:0] wUpdatedPC;

    int checkCount = 0;
    int failCount  = 0;

    logic        memPending;
    int          memDelay;
    int          memLat;
    logic [31:0] memAddr;
    logic [31:0] dataTag;
    logic        wMemPending;
    logic [31:0] wMemAddr;

    logic [31:0] reqAddrs[$];
    logic [31:0] popInstr[$];
    logic [31:0] popPc[$];
    logic [31:0] wReqAddrs[$];
    logic [31:0] wPopPc[$];

    logic        obsReq;
    logic [31:0] obsAddr;
    logic        obsValid;
    logic [31:0] obsInstr;
    logic [31:0] obsUpd;
    logic [31:0] wObsAddr;

    always #5 Clk = ~Clk;

    fetch_prefetch_queue dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemValid  (IMemValid),
        .IMemData   (IMemData),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .Instruction(Instruction),
        .UpdatedPC  (UpdatedPC)
    );

    fetch_prefetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
        .Clk        (Clk),
        .Reset      (Reset),
        .Redirect   (wRedirect),
        .RedirectPC (wRedirectPC),
        .IMemReq    (wReq),
        .IMemAddr   (wAddr),
        .IMemValid  (wValid),
        .IMemData   (wData),
        .InstrValid (wInstrValid),
        .InstrReady (wReady),
        .Instruction(wInstruction),
        .UpdatedPC  (wUpdatedPC)
    );

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One clock cycle: drive inputs, play the memory models, sample at the falling edge.
    task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic rdy);
        Redirect   = redir;
        RedirectPC = rpc;
        InstrReady = rdy;
        IMemValid  = 1'b0;
        IMemData   = '0;
        if (memPending) begin
            memDelay--;
            if (memDelay == 0) begin
                IMemValid  = 1'b1;
                IMemData   = dataTag | memAddr;
                memPending = 1'b0;
            end
        end
        wValid = 1'b0;
        wData  = '0;
        if (wMemPending) begin
            wValid      = 1'b1;
            wData       = 32'hB000_0000 ^ wMemAddr;
            wMemPending = 1'b0;
        end
        @(negedge Clk);
        obsReq   = IMemReq;
        obsAddr  = IMemAddr;
        obsValid = InstrValid;
        obsInstr = Instruction;
        obsUpd   = UpdatedPC;
        wObsAddr = wAddr;
        if (IMemReq) begin
            reqAddrs.push_back(IMemAddr);
            memPending = 1'b1;
            memDelay   = memLat;
            memAddr    = IMemAddr;
        end
        if (InstrValid && InstrReady) begin
            popInstr.push_back(Instruction);
            popPc.push_back(UpdatedPC);
        end
        if (wReq) begin
            wReqAddrs.push_back(wAddr);
            wMemPending = 1'b1;
            wMemAddr    = wAddr;
        end
        if (wInstrValid) wPopPc.push_back(wUpdatedPC);
        @(posedge Clk);
        #1;
    endtask

    task automatic doReset();
        Reset       = 1'b0;
        memPending  = 1'b0;
        wMemPending = 1'b0;
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b0);
        Reset = 1'b1;
        reqAddrs.delete();
        popInstr.delete();
        popPc.delete();
        wReqAddrs.delete();
        wPopPc.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        wRedirect   = 1'b0;
        wRedirectPC = '0;
        wReady      = 1'b1;
        memLat      = 1;
        dataTag     = 32'hC000_0000;
        memAddr     = '0;
        memDelay    = 0;
        wMemAddr    = '0;

        $display("[TB] test 1: sequential fetch, latency 1, consumer always ready");
        doReset();
        checkOutput("reset IMemReq", 32'(obsReq), 32'd0);
        checkOutput("reset IMemAddr", obsAddr, 32'h0);
        checkOutput("reset InstrValid", 32'(obsValid), 32'd0);
        checkOutput("reset Instruction", obsInstr, 32'h0);
        checkOutput("reset UpdatedPC", obsUpd, 32'h0);
        checkOutput("reset wrap IMemAddr", wObsAddr, 32'hFFFF_FFF8);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t1 req%0d", i), at(reqAddrs, i), 32'(4 * i));
            checkOutput($sformatf("t1 instr%0d", i), at(popInstr, i), 32'hC000_0000 | 32'(4 * i));
            checkOutput($sformatf("t1 pc%0d", i), at(popPc, i), 32'(4 * i + 4));
        end

        $display("[TB] test 5: PC wrap from FFFF_FFF8");
        checkOutput("t5 req0", at(wReqAddrs, 0), 32'hFFFF_FFF8);
        checkOutput("t5 req1", at(wReqAddrs, 1), 32'hFFFF_FFFC);
        checkOutput("t5 req2", at(wReqAddrs, 2), 32'h0000_0000);
        checkOutput("t5 pc1", at(wPopPc, 1), 32'h0000_0000);
        checkOutput("t5 pc2", at(wPopPc, 2), 32'h0000_0004);

        $display("[TB] test 2: back-pressure fills the queue");
        doReset();
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t2 req count full", 32'(reqAddrs.size()), 32'd4);
        checkOutput("t2 req3", at(reqAddrs, 3), 32'd12);
        checkOutput("t2 full IMemReq", 32'(obsReq), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t2 pop-cycle IMemReq", 32'(obsReq), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t2 pops", 32'(popPc.size()), 32'd1);
        checkOutput("t2 pop pc", at(popPc, 0), 32'd4);
        checkOutput("t2 req count after pop", 32'(reqAddrs.size()), 32'd5);
        checkOutput("t2 refill addr", at(reqAddrs, 4), 32'd16);

        $display("[TB] test 3: redirect while waiting, latency 3");
        doReset();
        memLat = 3;
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h100, 1'b1);
        checkOutput("t3 redirect InstrValid", 32'(obsValid), 32'd0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t3 pops", 32'(popPc.size()), 32'd1);
        checkOutput("t3 instr", at(popInstr, 0), 32'hC000_0100);
        checkOutput("t3 pc", at(popPc, 0), 32'h104);
        checkOutput("t3 req count", 32'(reqAddrs.size()), 32'd3);
        checkOutput("t3 target req", at(reqAddrs, 1), 32'h100);
        checkOutput("t3 next req", at(reqAddrs, 2), 32'h104);

        $display("[TB] test 4: redirect coincides with a response, two entries queued");
        doReset();
        memLat = 1;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t4 head valid", 32'(obsValid), 32'd1);
        checkOutput("t4 head pc", obsUpd, 32'd4);
        applyStimulus(1'b1, 32'h200, 1'b0);
        checkOutput("t4 redirect InstrValid", 32'(obsValid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t4 flushed InstrValid", 32'(obsValid), 32'd0);
        checkOutput("t4 IMemReq", 32'(obsReq), 32'd1);
        checkOutput("t4 IMemAddr", obsAddr, 32'h200);
        applyStimulus(1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("t4 new valid", 32'(obsValid), 32'd1);
        checkOutput("t4 new instr", obsInstr, 32'hC000_0200);
        checkOutput("t4 new pc", obsUpd, 32'h204);

        $display("[TB] test 6: response to empty queue");
        doReset();
        dataTag = 32'hA5A5_0001;
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
`ifdef PFQ_BYPASS_EN
        checkOutput("t6 bypass valid", 32'(obsValid), 32'd1);
        checkOutput("t6 bypass instr", obsInstr, 32'hA5A5_0001);
        checkOutput("t6 bypass pc", obsUpd, 32'd4);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t6 queue stays empty", 32'(obsValid), 32'd0);
`else
        checkOutput("t6 same-cycle valid", 32'(obsValid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t6 queued valid", 32'(obsValid), 32'd1);
        checkOutput("t6 queued instr", obsInstr, 32'hA5A5_0001);
        checkOutput("t6 queued pc", obsUpd, 32'd4);
`endif
        checkOutput("t6 next IMemReq", 32'(obsReq), 32'd1);
        checkOutput("t6 next IMemAddr", obsAddr, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
